// File: rtl/command_queue_pkg.sv
// Shared definitions for the timing-generator command queue.
//   - Instruction bit positions and ACTION encodings.
//   - reserved_mask(): builds the reserved-bit mask for a given instruction width.
//   - command_t: one packed queue entry at the default field widths.
package command_pkg;

    localparam int INSTR_DIRECTION_BIT = 0;
    localparam int INSTR_ACTION_BIT    = 1;

    localparam logic ACTION_DWELL = 1'b0;
    localparam logic ACTION_PULSE = 1'b1;

    localparam int CMD_SIGNAL_W = 32;
    localparam int CMD_INSTR_W  = 4;

    typedef struct packed {
        logic [CMD_INSTR_W-1:0]  instruction;
        logic [CMD_SIGNAL_W-1:0] pulse_period;
        logic [CMD_SIGNAL_W-1:0] pulse_count;
        logic [CMD_SIGNAL_W-1:0] pulse_width;
    } command_t;

    // Every instruction bit above DIRECTION and ACTION is reserved.
    // The result is built in 64 bits so that a width of 32 does not overflow the shift.
    function automatic logic [31:0] reserved_mask(input int width);
        logic [63:0] all_bits;
        all_bits = (64'd1 << width) - 64'd1;
        all_bits[INSTR_DIRECTION_BIT] = 1'b0;
        all_bits[INSTR_ACTION_BIT]    = 1'b0;
        return all_bits[31:0];
    endfunction

endpackage

// File: rtl/command_queue_if.sv
// Insert/remove bundle of the command queue.
//   master : host bridge / consumer side (drives requests, clear and write data)
//   slave  : the queue itself (drives read data, status and error flags)
interface command_queue_if #(
    parameter int C_DEPTH             = 16,
    parameter int C_SIGNAL_WIDTH      = 32,
    parameter int C_INSTRUCTION_WIDTH = 4
);
    localparam int LW = $clog2(C_DEPTH + 1);

    logic                           clear_buffer;
    logic                           insert_signal;
    logic [C_INSTRUCTION_WIDTH-1:0] insert_instruction;
    logic [C_SIGNAL_WIDTH-1:0]      insert_pulse_period;
    logic [C_SIGNAL_WIDTH-1:0]      insert_pulse_count;
    logic [C_SIGNAL_WIDTH-1:0]      insert_pulse_width;
    logic                           insert_buffer_full;
    logic                           almost_full;
    logic                           remove_signal;
    logic [C_INSTRUCTION_WIDTH-1:0] remove_instruction;
    logic [C_SIGNAL_WIDTH-1:0]      remove_pulse_period;
    logic [C_SIGNAL_WIDTH-1:0]      remove_pulse_count;
    logic [C_SIGNAL_WIDTH-1:0]      remove_pulse_width;
    logic                           remove_valid;
    logic                           remove_buffer_empty;
    logic [LW-1:0]                  level;
    logic                           overflow_error;
    logic                           underflow_error;
    logic                           instruction_error;

    modport master (
        output clear_buffer, insert_signal, insert_instruction,
               insert_pulse_period, insert_pulse_count, insert_pulse_width, remove_signal,
        input  insert_buffer_full, almost_full, remove_instruction, remove_pulse_period,
               remove_pulse_count, remove_pulse_width, remove_valid, remove_buffer_empty,
               level, overflow_error, underflow_error, instruction_error
    );

    modport slave (
        input  clear_buffer, insert_signal, insert_instruction,
               insert_pulse_period, insert_pulse_count, insert_pulse_width, remove_signal,
        output insert_buffer_full, almost_full, remove_instruction, remove_pulse_period,
               remove_pulse_count, remove_pulse_width, remove_valid, remove_buffer_empty,
               level, overflow_error, underflow_error, instruction_error
    );
endinterface

// File: rtl/command_queue_mem.sv
// Register-array entry storage for the command queue.
//   clock   : write clock
//   wr_en   : write strobe; wr_data lands at wr_addr on the clock edge
//   rd_addr : asynchronous read address; rd_data follows it combinationally
module command_queue_mem #(
    parameter int C_DEPTH = 16,
    parameter int C_WIDTH = 100
) (
    input  logic                       clock,
    input  logic                       wr_en,
    input  logic [$clog2(C_DEPTH)-1:0] wr_addr,
    input  logic [C_WIDTH-1:0]         wr_data,
    input  logic [$clog2(C_DEPTH)-1:0] rd_addr,
    output logic [C_WIDTH-1:0]         rd_data
);
    logic [C_WIDTH-1:0] mem_q [C_DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/command_queue.sv
// Single-clock command FIFO between the host bridge and the timing generator.
//   clock, reset : single clock, synchronous active-high reset
//   bus (slave)  : insert side (write request, command fields, full/almost_full),
//                  remove side (pop request, head/read data, valid, empty),
//                  fill level and sticky overflow/underflow/instruction error flags.
// C_SHOW_AHEAD=1 presents the head entry whenever the queue is non-empty;
// C_SHOW_AHEAD=0 registers the popped entry and pulses remove_valid for one cycle.
module command_queue
    import command_pkg::*;
#(
    parameter int C_DEPTH             = 16,
    parameter int C_SIGNAL_WIDTH      = CMD_SIGNAL_W,
    parameter int C_INSTRUCTION_WIDTH = CMD_INSTR_W,
    parameter int C_ALMOST_FULL       = 12,
    parameter int C_SHOW_AHEAD        = 1
) (
    input logic           clock,
    input logic           reset,
    command_queue_if.slave bus
);
    localparam int AW = $clog2(C_DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(C_DEPTH + 1);
    localparam logic [C_INSTRUCTION_WIDTH-1:0] RESERVED =
        C_INSTRUCTION_WIDTH'(reserved_mask(C_INSTRUCTION_WIDTH));

    typedef struct packed {
        logic [C_INSTRUCTION_WIDTH-1:0] instruction;
        logic [C_SIGNAL_WIDTH-1:0]      pulse_period;
        logic [C_SIGNAL_WIDTH-1:0]      pulse_count;
        logic [C_SIGNAL_WIDTH-1:0]      pulse_width;
    } entry_t;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d, unf_q, unf_d, ins_q, ins_d;
    logic          empty, full, wr_req, rd_req, wr_bad, wr_en, rd_en;
    entry_t        wr_entry, rd_entry;

    // The extra pointer bit separates "full" from "empty" when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A flush swallows any request made in the same cycle, errors included.
    assign wr_req = bus.insert_signal && !bus.clear_buffer;
    assign rd_req = bus.remove_signal && !bus.clear_buffer;
    assign wr_bad = (bus.insert_instruction & RESERVED) != '0;
    // Full is judged on registered state only, so a same-cycle pop cannot make room.
    assign wr_en  = wr_req && !full && !wr_bad;
    assign rd_en  = rd_req && !empty;

    assign wr_entry = {bus.insert_instruction, bus.insert_pulse_period,
                       bus.insert_pulse_count, bus.insert_pulse_width};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q | (wr_req && full);
        unf_d    = unf_q | (rd_req && empty);
        ins_d    = ins_q | (wr_req && wr_bad);
        if (bus.clear_buffer) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            ins_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            ins_q    <= ins_d;
        end
    end

    command_queue_mem #(.C_DEPTH(C_DEPTH), .C_WIDTH($bits(entry_t))) u_mem (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (rd_entry)
    );

    assign bus.insert_buffer_full  = full;
    assign bus.almost_full         = (level_q >= LW'(C_ALMOST_FULL));
    assign bus.remove_buffer_empty = empty;
    assign bus.level               = level_q;
    assign bus.overflow_error      = ovf_q;
    assign bus.underflow_error     = unf_q;
    assign bus.instruction_error   = ins_q;

    if (C_SHOW_AHEAD != 0) begin : g_show_ahead
        // Storage is not reset, so the head is forced to zero while nothing valid is held.
        entry_t head;
        assign head                    = empty ? '0 : rd_entry;
        assign bus.remove_valid        = !empty;
        assign bus.remove_instruction  = head.instruction;
        assign bus.remove_pulse_period = head.pulse_period;
        assign bus.remove_pulse_count  = head.pulse_count;
        assign bus.remove_pulse_width  = head.pulse_width;
    end else begin : g_normal
        entry_t out_q, out_d;
        logic   vld_q, vld_d;

        // Read data holds between pops; valid is a single-cycle strobe.
        always_comb begin
            out_d = out_q;
            vld_d = 1'b0;
            if (rd_en) begin
                out_d = rd_entry;
                vld_d = 1'b1;
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                out_q <= '0;
                vld_q <= 1'b0;
            end else begin
                out_q <= out_d;
                vld_q <= vld_d;
            end
        end

        assign bus.remove_valid        = vld_q;
        assign bus.remove_instruction  = out_q.instruction;
        assign bus.remove_pulse_period = out_q.pulse_period;
        assign bus.remove_pulse_count  = out_q.pulse_count;
        assign bus.remove_pulse_width  = out_q.pulse_width;
    end
endmodule
